// File: rtl/ffstdp_pkg.sv
// Shared definitions for the FF-STDP weight-update sequencer:
// sweep FSM encoding and the read-to-write-back pipeline depth.
package ffstdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_t;

    // One cycle of SRAM read latency plus one register stage inside the update unit.
    localparam int PIPE_DEPTH = 2;

endpackage : ffstdp_pkg

// File: rtl/ffstdp_pipe_tag.sv
// Valid + address delay line that follows each SRAM read until its write-back cycle.
module ffstdp_pipe_tag #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  pending
);

    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            addr_q[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    // Entries that have not yet reached their write-back stage.
    assign pending   = |valid_q[DEPTH-2:0];

endmodule : ffstdp_pipe_tag

// File: rtl/ffstdp_sram_sequencer.sv
// Sweeps every synapse row of the weight SRAM once per update: reads {grad, weight},
// lets the external update unit compute new values, and writes them back two cycles later.
module ffstdp_sram_sequencer
    import ffstdp_pkg::*;
#(
    parameter int N_PRE        = 256,
    parameter int ADDR_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int GRAD_WIDTH   = 8
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               START,
    input  logic                               HOLD,
    output logic                               BUSY,
    output logic                               DONE,
    output logic                               SRAM_RE,
    output logic [ADDR_WIDTH-1:0]              SRAM_RADDR,
    input  logic [GRAD_WIDTH+WEIGHT_WIDTH-1:0] SRAM_RDATA,
    output logic                               SRAM_WE,
    output logic [ADDR_WIDTH-1:0]              SRAM_WADDR,
    output logic [GRAD_WIDTH+WEIGHT_WIDTH-1:0] SRAM_WDATA,
    output logic [WEIGHT_WIDTH-1:0]            UPD_WSYN_CURR,
    output logic [GRAD_WIDTH-1:0]              UPD_GRAD_CURR,
    output logic [ADDR_WIDTH-1:0]              UPD_PRE_IDX,
    output logic                               UPD_EVENT,
    input  logic [WEIGHT_WIDTH-1:0]            WSYN_NEW,
    input  logic [GRAD_WIDTH-1:0]              GRAD_NEW
);

    // One extra counter bit so the post-increment after the last row never wraps to 0.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(N_PRE - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    seq_state_t          state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic                pipe_pending;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        SRAM_RE = 1'b0;
        DONE    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!HOLD) begin
                    SRAM_RE = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last entry may still be writing back this cycle; that is fine.
                if (!pipe_pending) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY       = (state_q != ST_IDLE);
    assign SRAM_RADDR = cnt_q[ADDR_WIDTH-1:0];

    ffstdp_pipe_tag #(
        .DEPTH      (PIPE_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pipe_tag (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (SRAM_RE),
        .in_addr   (SRAM_RADDR),
        .out_valid (wb_valid),
        .out_addr  (wb_addr),
        .pending   (pipe_pending)
    );

    assign UPD_WSYN_CURR = SRAM_RDATA[WEIGHT_WIDTH-1:0];
    assign UPD_GRAD_CURR = SRAM_RDATA[GRAD_WIDTH+WEIGHT_WIDTH-1:WEIGHT_WIDTH];

    assign UPD_PRE_IDX = wb_addr;
    assign UPD_EVENT   = wb_valid;
    assign SRAM_WE     = wb_valid;
    assign SRAM_WADDR  = wb_addr;
    assign SRAM_WDATA  = {GRAD_NEW, WSYN_NEW};

endmodule : ffstdp_sram_sequencer

// File: doc/ffstdp_sram_sequencer.md
FFSTDP_SRAM_SEQUENCER -- requirements
Module: ffstdp_sram_sequencer

Interface
REQ-001 SHALL have parameter N_PRE, default 256; number of synapse rows swept per update.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8; width of the SRAM address, equal to clog2(N_PRE).
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8; width of the signed weight field.
REQ-004 SHALL have parameter GRAD_WIDTH, default 8; width of the signed gradient field.
REQ-005 SHALL have port CLK, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit; asynchronous active-low reset.
REQ-007 SHALL have port START, input, 1 bit; single-cycle sweep request from the controller.
REQ-008 SHALL have port HOLD, input, 1 bit; SRAM port taken by the inference path, so no new read is issued.
REQ-009 SHALL have port BUSY, output, 1 bit; a sweep is in progress.
REQ-010 SHALL have port DONE, output, 1 bit; one-cycle pulse after the last write-back.
REQ-011 SHALL have port SRAM_RE, output, 1 bit; SRAM read enable.
REQ-012 SHALL have port SRAM_RADDR, output, ADDR_WIDTH bits; SRAM read address.
REQ-013 SHALL have port SRAM_RDATA, input, GRAD_WIDTH+WEIGHT_WIDTH bits; read data {grad, weight}, valid one cycle after SRAM_RE.
REQ-014 SHALL have port SRAM_WE, output, 1 bit; SRAM write enable.
REQ-015 SHALL have port SRAM_WADDR, output, ADDR_WIDTH bits; SRAM write address.
REQ-016 SHALL have port SRAM_WDATA, output, GRAD_WIDTH+WEIGHT_WIDTH bits; write data {GRAD_NEW, WSYN_NEW}.
REQ-017 SHALL have ports UPD_WSYN_CURR, output, WEIGHT_WIDTH bits, and UPD_GRAD_CURR, output, GRAD_WIDTH bits; the SRAM fields forwarded to the update unit.
REQ-018 SHALL have port UPD_PRE_IDX, output, ADDR_WIDTH bits; row index, aligned with the update unit's registered stage, that selects the pre-spike count.
REQ-019 SHALL have port UPD_EVENT, output, 1 bit; drives the update unit's CTRL_TREF_EVENT and is high exactly in write-back cycles.
REQ-020 SHALL have ports WSYN_NEW, input, WEIGHT_WIDTH bits, and GRAD_NEW, input, GRAD_WIDTH bits; results returned by the update unit.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, DRAIN and FIN.
REQ-022 SHALL in IDLE, on START, load the read counter with 0 and go to ISSUE; START received outside IDLE is ignored.
REQ-023 SHALL in ISSUE with HOLD=0 assert SRAM_RE with SRAM_RADDR equal to the counter, then increment the counter.
REQ-024 SHALL in ISSUE with HOLD=1 deassert SRAM_RE and keep the counter; operations already in flight continue.
REQ-025 SHALL pass UPD_WSYN_CURR and UPD_GRAD_CURR combinationally from SRAM_RDATA.
REQ-026 SHALL, for a read issued at cycle t, drive UPD_PRE_IDX to its address at t+2, because the update unit registers data at the end of t+1.
REQ-027 SHALL, for a read issued at cycle t, assert SRAM_WE and UPD_EVENT at t+2 with SRAM_WADDR equal to that address and SRAM_WDATA equal to {GRAD_NEW, WSYN_NEW}; this is achieved with a 2-deep valid/address shift pipeline.
REQ-028 SHALL, after issuing address N_PRE-1, go to DRAIN; DRAIN waits until the pipeline is empty and then goes to FIN.
REQ-029 SHALL in FIN pulse DONE for one cycle and return to IDLE.
REQ-030 SHALL hold BUSY high from the cycle after START until the DONE cycle inclusive.
REQ-031 SHALL issue every address exactly once, in ascending order, and write back every address exactly once.
REQ-032 SHALL never have SRAM read and write at the same address in the same cycle, since reads run 2 addresses ahead.
REQ-033 SHALL, with N_PRE=1, issue a single read and then go to DRAIN.
REQ-034 SHALL not let the counter wrap; the read counter is ADDR_WIDTH+1 bits wide.

Reset
REQ-035 SHALL, while RST_N=0, immediately and asynchronously set the FSM to IDLE, the counter and pipeline valids to 0, and SRAM_RE, SRAM_WE, UPD_EVENT, BUSY and DONE to 0.
REQ-036 SHALL drive all address outputs to 0 during reset.
REQ-037 SHALL, on reset mid-sweep, drop all in-flight writes; a new START restarts the sweep at address 0.

Structure
REQ-038 SHALL place the FSM state encoding and the pipeline depth constant (2) in the shared package ffstdp_pkg.
REQ-039 SHALL use one sub-module, ffstdp_pipe_tag, a parameterised valid+address delay line.
REQ-040 SHALL instantiate the update unit outside this block, not inside it.

Verification
REQ-041 SHALL verify: N_PRE=4, START with HOLD=0 -> reads at t1..t4 for addresses 0..3, writes at t3..t6, DONE at t7, BUSY high t1..t7.
REQ-042 SHALL verify: a HOLD pulse of 3 cycles after address 1 is issued -> no read for 3 cycles, the write for address 1 still occurs, all 4 addresses are written once.
REQ-043 SHALL verify: START asserted again during BUSY -> ignored, exactly N_PRE writes, one DONE.
REQ-044 SHALL verify: RST_N low after write 2 of 8 -> SRAM_WE=0 at once, and a new START writes addresses 0..7.
REQ-045 SHALL verify: with a stub update unit, WSYN_NEW=0x7F and GRAD_NEW=0x00 -> SRAM_WDATA=0x007F at the write address matching the delayed UPD_PRE_IDX.
REQ-046 SHALL verify: N_PRE=1 -> one read, one write 2 cycles later, DONE the cycle after.
